// File: rtl/subtrator_pkg.sv
// subtrator_pkg: shared definitions for the bit-serial subtractor.
//   SUB_WIDTH : default operand/result width
//   estado_t  : controller states (IDLE, CALC, FIM)
//   cnt_width : width of a counter that must reach the value w
package subtrator_pkg;

   localparam int unsigned SUB_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIM  = 2'd2
   } estado_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/SubtratorPBL1.sv
// SubtratorPBL1: single-bit full-subtractor cell, computes A - B - Bin.
// Ports:
//   A, B  - minuend and subtrahend bits
//   Bin   - borrow in
//   D     - difference bit
//   Bout  - borrow out
module SubtratorPBL1 (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   always_comb begin
      D    = A ^ B ^ Bin;
      Bout = (~A & B) | (~(A ^ B) & Bin);
   end

endmodule

// File: rtl/subtrator_serial_4bits.sv
// subtrator_serial_4bits: bit-serial D = A - B using one full-subtractor cell,
// LSB first, one bit per clock, with a start/busy/done handshake.
// Optional feature macro: SUBTRATOR_OVERFLOW_EN adds the registered OVF output.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - launch request, sampled only in IDLE
//   A, B   - operands, captured on the accepting edge
//   busy   - high in CALC and FIM
//   done   - one-cycle pulse when D/Bout (and OVF) are valid
//   D      - registered difference modulo 2^WIDTH
//   Bout   - registered final borrow (A < B unsigned)
//   OVF    - registered signed overflow (SUBTRATOR_OVERFLOW_EN only)
module subtrator_serial_4bits
   import subtrator_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
`ifdef SUBTRATOR_OVERFLOW_EN
   ,
   output logic             OVF
`endif
);

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   estado_t          state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CntW-1:0]  cnt;

   logic             cell_d;
   logic             cell_bout;
   logic [WIDTH-1:0] res_next;

`ifdef SUBTRATOR_OVERFLOW_EN
   // Operand sign bits are shifted out during CALC, so keep a copy.
   logic             a_msb;
   logic             b_msb;
`endif

   SubtratorPBL1 u_cell (
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .Bin  (borrow),
      .D    (cell_d),
      .Bout (cell_bout)
   );

   // New difference bit enters from the MSB side so bit 0 ends at D[0].
   always_comb begin
      res_next = {cell_d, res_sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         D      <= '0;
         Bout   <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         OVF    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  res_sr <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
`ifdef SUBTRATOR_OVERFLOW_EN
                  a_msb  <= A[WIDTH-1];
                  b_msb  <= B[WIDTH-1];
`endif
               end
            end

            CALC: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= cell_bout;
               cnt    <= cnt + 1'b1;
               if (cnt == LastBit) begin
                  // Last bit is the MSB: publish the full result on this edge.
                  D     <= res_next;
                  Bout  <= cell_bout;
                  done  <= 1'b1;
                  state <= FIM;
`ifdef SUBTRATOR_OVERFLOW_EN
                  OVF   <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
               end
            end

            FIM: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subtrator_serial_4bits.sv
module tb_subtrator_serial_4bits;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic [3:0] D;
   logic       Bout;
   logic       OVF;

   int tests = 0;
   int fails = 0;
   logic [3:0] last_d = 4'd0;

   subtrator_serial_4bits dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout)
`ifdef SUBTRATOR_OVERFLOW_EN
      ,
      .OVF   (OVF)
`endif
   );

`ifndef SUBTRATOR_OVERFLOW_EN
   assign OVF = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arithmetic on the operand values.
   function automatic logic [3:0] model_d(input logic [3:0] a, input logic [3:0] b);
      int r;
      r = (int'(a) - int'(b)) & 15;
      return r[3:0];
   endfunction

   function automatic logic model_bout(input logic [3:0] a, input logic [3:0] b);
      return int'(a) < int'(b);
   endfunction

   function automatic logic model_ovf(input logic [3:0] a, input logic [3:0] b);
      int sa, sb, df;
      sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
      sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
      df = sa - sb;
      return (df < -8) || (df > 7);
   endfunction

   // Launch one operation and return what was observed; ends back in IDLE.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat,
                         output logic [3:0] d_mid, output logic [3:0] d_o,
                         output logic bo_o, output logic ovf_o);
      lat   = -1;
      d_mid = 4'bx;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = 4'($urandom); B = 4'($urandom);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 2) d_mid = D;
         if (done) begin
            lat = c;
            break;
         end
      end
      d_o   = D;
      bo_o  = Bout;
      ovf_o = OVF;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; A = 4'hF; B = 4'hF;
      #23;
      tests++;
      if ({busy, done, D, Bout, OVF} !== 8'b0) begin
         fails++;
         $display("FAIL reset_outputs got busy=%b done=%b D=%h Bout=%b OVF=%b want all 0",
                  busy, done, D, Bout, OVF);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_start got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      logic [3:0] av[3] = '{4'd9, 4'd3, 4'd15};
      logic [3:0] bv[3] = '{4'd3, 4'd9, 4'd15};
      int lat; logic [3:0] dm, dd; logic bo, ov;
      for (int i = 0; i < 3; i++) begin
         run_op(av[i], bv[i], lat, dm, dd, bo, ov);
         tests++;
         if (lat !== 4) begin
            fails++;
            $display("FAIL directed_latency[%0d] got %0d want 4", i, lat);
         end
         tests++;
         if (dd !== model_d(av[i], bv[i]) || bo !== model_bout(av[i], bv[i])) begin
            fails++;
            $display("FAIL directed_result[%0d] got D=%h Bout=%b want D=%h Bout=%b",
                     i, dd, bo, model_d(av[i], bv[i]), model_bout(av[i], bv[i]));
         end
         tests++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL directed_idle[%0d] got busy=%b done=%b want 0 0", i, busy, done);
         end
         last_d = model_d(av[i], bv[i]);
      end
   endtask

   task automatic test_random();
      int lat; logic [3:0] dm, dd, a, b; logic bo, ov;
      for (int i = 0; i < 24; i++) begin
         a = 4'($urandom); b = 4'($urandom);
         run_op(a, b, lat, dm, dd, bo, ov);
         tests++;
         if (lat !== 4 || dm !== last_d) begin
            fails++;
            $display("FAIL random_timing[%0d] got lat=%0d midD=%h want lat=4 midD=%h",
                     i, lat, dm, last_d);
         end
         tests++;
         if (dd !== model_d(a, b) || bo !== model_bout(a, b)) begin
            fails++;
            $display("FAIL random_result[%0d] a=%h b=%h got D=%h Bout=%b want D=%h Bout=%b",
                     i, a, b, dd, bo, model_d(a, b), model_bout(a, b));
         end
         last_d = model_d(a, b);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      int pulses = 0;
      @(negedge clk);
      A = 4'd5; B = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         if (done !== ((c % 6) == 4) || busy !== ((c % 6) != 5)) bad++;
         if (done) begin
            pulses++;
            if (D !== model_d(4'd5, 4'd2)) bad++;
         end
      end
      @(negedge clk); start = 1'b0;
      tests++;
      if (bad !== 0 || pulses !== 3) begin
         fails++;
         $display("FAIL back_to_back got bad_cycles=%0d pulses=%0d want 0 and 3", bad, pulses);
      end
      for (int c = 0; c < 12 && busy; c++) @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL back_to_back_drain got busy=%b want 0", busy);
      end
      last_d = model_d(4'd5, 4'd2);
   endtask

   task automatic test_ignore_start();
      int pulses = 0;
      logic [3:0] dseen = 4'hx;
      @(negedge clk);
      A = 4'd7; B = 4'd1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      A = 4'd0; B = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            dseen = D;
         end
      end
      tests++;
      if (pulses !== 1 || dseen !== model_d(4'd7, 4'd1)) begin
         fails++;
         $display("FAIL ignore_start got pulses=%0d D=%h want 1 and %h",
                  pulses, dseen, model_d(4'd7, 4'd1));
      end
      last_d = model_d(4'd7, 4'd1);
   endtask

   task automatic test_reset_mid();
      int lat; logic [3:0] dm, dd; logic bo, ov;
      int pulses = 0;
      run_op(4'd9, 4'd3, lat, dm, dd, bo, ov);
      @(negedge clk);
      A = 4'd2; B = 4'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #3; rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, D, Bout} !== 7'b0) begin
         fails++;
         $display("FAIL reset_mid got busy=%b done=%b D=%h Bout=%b want all 0",
                  busy, done, D, Bout);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      tests++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL reset_mid_quiet got active_cycles=%0d want 0", pulses);
      end
      last_d = 4'd0;
      run_op(4'd12, 4'd5, lat, dm, dd, bo, ov);
      tests++;
      if (lat !== 4 || dd !== model_d(4'd12, 4'd5) || bo !== model_bout(4'd12, 4'd5)) begin
         fails++;
         $display("FAIL reset_mid_restart got lat=%0d D=%h Bout=%b want 4 %h %b",
                  lat, dd, bo, model_d(4'd12, 4'd5), model_bout(4'd12, 4'd5));
      end
      last_d = model_d(4'd12, 4'd5);
   endtask

`ifdef SUBTRATOR_OVERFLOW_EN
   task automatic test_ovf();
      int lat; logic [3:0] dm, dd, a, b; logic bo, ov;
      for (int i = 0; i < 18; i++) begin
         if (i == 0) begin a = 4'd8; b = 4'd1; end
         else if (i == 1) begin a = 4'd5; b = 4'd2; end
         else begin a = 4'($urandom); b = 4'($urandom); end
         run_op(a, b, lat, dm, dd, bo, ov);
         tests++;
         if (dd !== model_d(a, b) || bo !== model_bout(a, b) || ov !== model_ovf(a, b)) begin
            fails++;
            $display("FAIL ovf[%0d] a=%h b=%h got D=%h Bout=%b OVF=%b want %h %b %b",
                     i, a, b, dd, bo, ov, model_d(a, b), model_bout(a, b), model_ovf(a, b));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
`ifdef SUBTRATOR_OVERFLOW_EN
      test_ovf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
